// File: rtl/bram_access_arbiter_if.sv
// Bundle of the Wishbone slave, accelerator port and BRAM port seen by the arbiter.
// slave = the arbiter itself; master = the requesters plus the BRAM data return.
interface bram_access_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              acc_req;
  logic [3:0]        acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_ack;
  logic [31:0]       acc_rdata;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [31:0]       bram_addr;
  logic [31:0]       bram_di;
  logic [31:0]       bram_do;
  logic              busy;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  acc_req, acc_we, acc_addr, acc_wdata, bram_do,
    output wbs_ack_o, wbs_dat_o, acc_ack, acc_rdata,
    output bram_en, bram_we, bram_addr, bram_di, busy
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output acc_req, acc_we, acc_addr, acc_wdata, bram_do,
    input  wbs_ack_o, wbs_dat_o, acc_ack, acc_rdata,
    input  bram_en, bram_we, bram_addr, bram_di, busy
  );
endinterface

// File: rtl/bram_access_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the Wishbone slave
// path and the accelerator; one enable per grant, programmable wait, 1-cycle ack.
module bram_access_arbiter #(
  parameter int          DELAYS  = 10,
  parameter logic [11:0] WB_BASE = 12'h380,
  parameter int          ADDR_W  = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rstn_i,
  bram_access_arbiter_if.slave  bus
);

  localparam int NDLY = (DELAYS < 1) ? 1 : DELAYS;
  localparam int CW   = (NDLY < 2) ? 1 : $clog2(NDLY);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
  typedef enum logic {ID_WB = 1'b0, ID_ACC = 1'b1} req_id_t;

  typedef struct packed {
    req_id_t           id;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  req_id_t       last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          abort_q, abort_d;

  logic       wb_req, grant_acc, last_wait, wb_gone;
  logic [3:0] wb_we;

  assign wb_req    = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:20] == WB_BASE);
  assign wb_we     = bus.wbs_sel_i & {4{bus.wbs_we_i}};
  assign last_wait = (cnt_q == CW'(NDLY - 1));
  // Only a Wishbone owner can abandon its cycle; the BRAM access still completes.
  assign wb_gone   = (cmd_q.id == ID_WB) & ~bus.wbs_cyc_i;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      last_q  <= ID_ACC;
      cnt_q   <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    abort_d   = abort_q;
    grant_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_req | bus.acc_req) begin
          // On a tie the side that did not win last time goes first.
          grant_acc = bus.acc_req & (~wb_req | (last_q == ID_WB));
          if (grant_acc) begin
            cmd_d.id    = ID_ACC;
            cmd_d.we    = bus.acc_we;
            cmd_d.addr  = bus.acc_addr;
            cmd_d.wdata = bus.acc_wdata;
          end else begin
            cmd_d.id    = ID_WB;
            cmd_d.we    = wb_we;
            cmd_d.addr  = bus.wbs_adr_i[ADDR_W-1:0];
            cmd_d.wdata = bus.wbs_dat_i;
          end
          last_d  = cmd_d.id;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wb_gone) abort_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (wb_gone) abort_d = 1'b1;
        if (last_wait) begin
          rdata_d = bus.bram_do;
          state_d = (abort_q | wb_gone) ? IDLE : ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.bram_en   = (state_q == ACCESS);
  assign bus.bram_we   = (state_q == ACCESS) ? cmd_q.we : 4'h0;
  assign bus.bram_addr = 32'(cmd_q.addr);
  assign bus.bram_di   = cmd_q.wdata;
  assign bus.wbs_ack_o = (state_q == ACK) & (cmd_q.id == ID_WB);
  assign bus.acc_ack   = (state_q == ACK) & (cmd_q.id == ID_ACC);
  assign bus.wbs_dat_o = rdata_q;
  assign bus.acc_rdata = rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Directed bench for bram_access_arbiter with a 1-cycle-latency BRAM model.
module tb_bram_access_arbiter;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bram_access_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  bram_access_arbiter #(.DELAYS(10), .WB_BASE(12'h380), .ADDR_W(ADDR_W)) dut (
    .wb_clk_i (clk),
    .wb_rstn_i(rstn),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cnt = 0, wack_cnt = 0, aack_cnt = 0;
  logic [3:0]  en_we;
  logic [31:0] en_addr, en_di;
  logic [31:0] mem [0:255];
  logic [31:0] wb_dat, acc_dat;

  // BRAM model: read-first, data held until the next enable
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.bram_en) begin
      en_cnt  <= en_cnt + 1;
      en_we   <= bus.bram_we;
      en_addr <= bus.bram_addr;
      en_di   <= bus.bram_di;
      for (int b = 0; b < 4; b++)
        if (bus.bram_we[b]) mem[bus.bram_addr[9:2]][8*b +: 8] <= bus.bram_di[8*b +: 8];
      bus.bram_do <= mem[bus.bram_addr[9:2]];
    end
    if (bus.wbs_ack_o) wack_cnt <= wack_cnt + 1;
    if (bus.acc_ack)   aack_cnt <= aack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
  endtask

  task automatic drive_acc(input logic [3:0] we, input logic [15:0] adr, input logic [31:0] dat);
    bus.acc_req = 1'b1; bus.acc_we = we; bus.acc_addr = adr; bus.acc_wdata = dat;
  endtask

  // Waits for the requested acks; returns cycles from start (-1 if none within bound).
  task automatic run(input bit want_wb, input bit want_acc, output int wb_at, output int acc_at);
    int s;
    s = cyc; wb_at = -1; acc_at = -1;
    while ((cyc < s + 40) && !((!want_wb || wb_at >= 0) && (!want_acc || acc_at >= 0))) begin
      @(negedge clk);
      if (bus.wbs_ack_o && wb_at < 0) begin
        wb_at = cyc - s; wb_dat = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      end
      if (bus.acc_ack && acc_at < 0) begin
        acc_at = cyc - s; acc_dat = bus.acc_rdata;
        bus.acc_req = 1'b0;
      end
    end
    step(1);
  endtask

  initial begin
    int wa, aa, e0, w0, a0, s, idle_at;
    bit busy_seen, ack_seen;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h11223344;
    mem[8] = 32'h12345678;
    bus.bram_do = 32'h0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    bus.acc_req = 0; bus.acc_we = 0; bus.acc_addr = 0; bus.acc_wdata = 0;

    step(3);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_en", 32'(bus.bram_en), 0);
    check("rst_acks", 32'({bus.wbs_ack_o, bus.acc_ack}), 0);
    check("rst_addr", bus.bram_addr, 0);
    rstn = 1'b1;
    step(1);

    // Wishbone full-word write
    e0 = en_cnt; w0 = wack_cnt; a0 = aack_cnt;
    drive_wb(1'b1, 32'h3800_0010, 32'hDEAD_BEEF);
    run(1, 0, wa, aa);
    check("wr_lat", wa, 12);
    check("wr_en_cnt", en_cnt - e0, 1);
    check("wr_we", 32'(en_we), 32'hF);
    check("wr_addr", en_addr, 32'h10);
    check("wr_di", en_di, 32'hDEAD_BEEF);
    check("wr_ack_cnt", wack_cnt - w0, 1);
    check("wr_mem", mem[4], 32'hDEAD_BEEF);

    // Wishbone read-back
    a0 = aack_cnt;
    drive_wb(1'b0, 32'h3800_0010, 32'h0);
    run(1, 0, wa, aa);
    check("rd_lat", wa, 12);
    check("rd_data", wb_dat, 32'hDEAD_BEEF);
    check("rd_we", 32'(en_we), 0);
    check("rd_no_acc_ack", aack_cnt - a0, 0);

    // Tie after a Wishbone grant: accelerator goes first
    drive_wb(1'b0, 32'h3800_0010, 32'h0);
    drive_acc(4'h0, 16'h0020, 32'h0);
    run(1, 1, wa, aa);
    check("rr1_acc_lat", aa, 12);
    check("rr1_wb_lat", wa, 25);
    check("rr1_acc_data", acc_dat, 32'h1234_5678);
    check("rr1_wb_data", wb_dat, 32'hDEAD_BEEF);

    // After reset the tie goes to Wishbone, and again on the repeat
    rstn = 1'b0; step(2); rstn = 1'b1; step(1);
    drive_wb(1'b0, 32'h3800_0010, 32'h0);
    drive_acc(4'h0, 16'h0020, 32'h0);
    run(1, 1, wa, aa);
    check("rr2_wb_lat", wa, 12);
    check("rr2_acc_lat", aa, 25);
    check("rr2_acc_data", acc_dat, 32'h1234_5678);
    drive_wb(1'b0, 32'h3800_0010, 32'h0);
    drive_acc(4'h0, 16'h0020, 32'h0);
    run(1, 1, wa, aa);
    check("rr3_wb_lat", wa, 12);
    check("rr3_acc_lat", aa, 25);

    // Accelerator byte-lane write
    w0 = wack_cnt;
    drive_acc(4'b0010, 16'h0004, 32'h0000_AB00);
    run(0, 1, wa, aa);
    check("bw_lat", aa, 12);
    check("bw_we", 32'(en_we), 32'h2);
    check("bw_addr", en_addr, 32'h4);
    check("bw_no_wb_ack", wack_cnt - w0, 0);
    check("bw_mem", mem[1], 32'h1122_AB44);

    // Reset in the middle of WAIT
    drive_wb(1'b0, 32'h3800_0010, 32'h0);
    step(5);
    check("mid_busy_pre", 32'(bus.busy), 1);
    check("mid_dat_pre", bus.wbs_dat_o, 32'h1122_3344);
    #2 rstn = 1'b0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    #1;
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_addr", bus.bram_addr, 0);
    check("mid_di", bus.bram_di, 0);
    check("mid_dat", {bus.wbs_dat_o ^ bus.acc_rdata} | bus.wbs_dat_o, 0);
    check("mid_en_we", 32'({bus.bram_en, bus.bram_we}), 0);
    step(2); rstn = 1'b1;
    e0 = en_cnt; w0 = wack_cnt; a0 = aack_cnt;
    step(20);
    check("mid_no_ack", (wack_cnt - w0) + (aack_cnt - a0), 0);
    check("mid_no_en", en_cnt - e0, 0);

    // Wishbone abort during WAIT cycle 3
    e0 = en_cnt; w0 = wack_cnt;
    drive_wb(1'b1, 32'h3800_0040, 32'hCAFE_F00D);
    s = cyc;
    step(4);
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    idle_at = -1; ack_seen = 0;
    while (cyc < s + 20) begin
      @(negedge clk);
      if (!bus.busy && idle_at < 0) idle_at = cyc - s;
      if (bus.wbs_ack_o) ack_seen = 1;
    end
    step(1);
    check("ab_en_cnt", en_cnt - e0, 1);
    check("ab_mem", mem[16], 32'hCAFE_F00D);
    check("ab_no_ack", 32'(ack_seen), 0);
    check("ab_ack_cnt", wack_cnt - w0, 0);
    check("ab_idle_at", idle_at, 12);

    // Access outside the Wishbone window
    e0 = en_cnt; w0 = wack_cnt;
    drive_wb(1'b1, 32'h3600_0000, 32'h5555_AAAA);
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1;
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    step(1);
    check("nd_no_en", en_cnt - e0, 0);
    check("nd_no_ack", wack_cnt - w0, 0);
    check("nd_busy", 32'(busy_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
